serial_fifo_writer: RTL and testbench
=====================================

Name: serial_fifo_writer

Overview:
- Write-side producer for the dual-clock FIFO.
- Receives an asynchronous-style serial frame on ser_in, sampled in the clk_write domain: start bit, DATA_SIZE data bits LSB first, stop bit.
- Holds each assembled word in a one-deep holding register and drives the FIFO write port, honouring fifo_full backpressure.
- Reports framing errors and dropped words (overflow).

Parameters:
- DATA_SIZE, 4, data bits per frame; must equal the FIFO's DATA_SIZE.
- BIT_CYCLES, 4, clk_write cycles per serial bit; even, >= 2.
- COUNT_WIDTH, 8, width of word_count.

Ports:
- clk_write  in  1  write-domain clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high; clock clk_write.
- ser_in  in  1  serial line; idle high; assumed already synchronised to clk_write.
- fifo_full  in  1  FIFO full flag.
- fifo_data  out  DATA_SIZE  holding-register contents; connects to the FIFO's data_in.
- fifo_write_mode  out  1  write request; equals hold_valid & ~fifo_full (combinational from registers and fifo_full).
- fifo_enable  out  1  FIFO enable; equals ~reset.
- frame_error  out  1  one-cycle pulse when the stop bit samples 0.
- overflow  out  1  sticky; set when a completed word is dropped; cleared only by reset.
- word_count  out  COUNT_WIDTH  number of words written into the FIFO; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset values: state IDLE; bit counter and bit index 0; shift register 0; hold_valid 0; fifo_data 0; frame_error 0; overflow 0; word_count 0.
- Reset has priority over every other event on the same edge. Reset mid-frame abandons the frame without any error or overflow indication.
- H = BIT_CYCLES/2. Edge E0 is the first edge that samples ser_in=0 while in IDLE.
- FSM states and transitions:
  - IDLE: ser_in==0 -> START, cnt=0.
  - START: increment cnt until cnt==H-1; at that edge (E_H) sample ser_in. If 0 -> DATA with cnt=0, idx=0. If 1 -> IDLE (glitch rejected, no error).
  - DATA: on the edge where cnt==BIT_CYCLES-1, shift ser_in into the MSB of the shift register (LSB-first assembly) and reset cnt. After DATA_SIZE samples -> STOP. Bit k is sampled at E_{H+k*BIT_CYCLES}, k=1..DATA_SIZE.
  - STOP: sample at E_{H+(DATA_SIZE+1)*BIT_CYCLES}. Always return to IDLE. If 0: frame_error=1 for one cycle and the word is discarded. If 1: word complete.
- Holding register, word complete on the same edge:
  - If hold_valid==0, or a write happens on this edge: load fifo_data, hold_valid=1.
  - Otherwise: drop the word, overflow=1, hold_valid and fifo_data unchanged.
- FIFO write on an edge where fifo_write_mode==1: hold_valid clears (unless reloaded on the same edge) and word_count increments.
- Latency: fifo_write_mode rises after edge E_{H+(DATA_SIZE+1)*BIT_CYCLES} (E22 with defaults), provided fifo_full==0. The FIFO captures the word at the next edge.
- fifo_full held high: the word stays in the holding register indefinitely; fifo_write_mode stays 0; fifo_data is stable.
- A new frame may start on the edge immediately after STOP.

Decomposition:
- Shared package serial_fifo_pkg:
  - state enum IDLE/START/DATA/STOP, 2-bit encoding.
  - localparams for the H computation and the bit-index width, $clog2(DATA_SIZE+1).
- One natural sub-module: serial_bit_timer. Parametrised by BIT_CYCLES; produces the mid-start tick and the per-bit sample tick; cleared on state entry.

Test Plan:
- Defaults; frame 0, bits 0,1,0,1, then 1, with fifo_full=0 -> fifo_write_mode high for one cycle after E22, fifo_data=4'hA, word_count=1, frame_error=0.
- ser_in low for 1 cycle only, then high -> START rejects at E2; state returns to IDLE; no write; no frame_error.
- Frame 0xA with stop bit 0 -> frame_error pulses one cycle at E22; hold_valid stays 0; word_count=0.
- fifo_full=1 and two back-to-back frames 0x3 then 0xC -> fifo_data holds 4'h3; overflow=1 after the second stop edge. Release fifo_full -> one write of 0x3, word_count=1.
- Assert reset during the DATA state of frame 0x5, then send frame 0x9 -> only 0x9 is written; overflow=0; frame_error=0.
- 256 consecutive valid frames -> word_count wraps to 0; no overflow.

Source files
------------

// File: rtl/serial_fifo_writer_pkg.sv
// Shared types and sizing helpers for the serial-to-FIFO write path.
package serial_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  localparam int unsigned DefaultDataSize  = 4;
  localparam int unsigned DefaultBitCycles = 4;

  function automatic int unsigned half_cycles(int unsigned bit_cycles);
    return bit_cycles / 2;
  endfunction

  function automatic int unsigned idx_width(int unsigned data_size);
    return $clog2(data_size + 1);
  endfunction

  localparam int unsigned DefaultHalf   = half_cycles(DefaultBitCycles);
  localparam int unsigned DefaultIdxW   = idx_width(DefaultDataSize);

endpackage

// File: rtl/serial_fifo_writer_if.sv
// FIFO write-port bundle between the serial writer (master) and the FIFO (slave).
interface serial_fifo_writer_if #(
  parameter int unsigned DATA_SIZE = 4
) ();

  logic                 fifo_full;
  logic [DATA_SIZE-1:0] fifo_data;
  logic                 fifo_write_mode;
  logic                 fifo_enable;

  modport master (
    input  fifo_full,
    output fifo_data,
    output fifo_write_mode,
    output fifo_enable
  );

  modport slave (
    output fifo_full,
    input  fifo_data,
    input  fifo_write_mode,
    input  fifo_enable
  );

endinterface

// File: rtl/serial_fifo_writer_bit_timer.sv
// Per-bit cycle counter: mid-start tick at H-1, sample tick at BIT_CYCLES-1.
module serial_bit_timer
  import serial_fifo_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk_write,
  input  logic reset,
  input  logic clear,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int unsigned H    = half_cycles(BIT_CYCLES);
  localparam int unsigned CntW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign mid_tick = (cnt_q == CntW'(H - 1));
  assign bit_tick = (cnt_q == CntW'(BIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk_write) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_fifo_writer.sv
// Serial frame receiver feeding the write port of a dual-clock FIFO through a
// one-deep holding register, with framing-error and overflow reporting.
module serial_fifo_writer
  import serial_fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = 4,
  parameter int unsigned BIT_CYCLES  = 4,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk_write,
  input  logic                   reset,
  input  logic                   ser_in,
  serial_fifo_writer_if.master   fifo,
  output logic                   frame_error,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int unsigned IdxW = idx_width(DATA_SIZE);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_SIZE-1:0]   shift_q, shift_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_error_q, frame_error_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   mid_tick, bit_tick, clear, word_done, write;

  // Counter restarts whenever a state is entered and idles at zero in StIdle.
  assign clear = (state_d != state_q) || (state_q == StIdle);

  serial_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk_write(clk_write),
    .reset    (reset),
    .clear    (clear),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    word_done     = 1'b0;
    frame_error_d = 1'b0;
    unique case (state_q)
      StIdle: if (!ser_in) state_d = StStart;
      StStart: begin
        if (mid_tick) begin
          state_d = ser_in ? StIdle : StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = {ser_in, shift_q[DATA_SIZE-1:1]};
          if (idx_q == IdxW'(DATA_SIZE - 1)) state_d = StStop;
          else                               idx_d   = idx_q + IdxW'(1);
        end
      end
      StStop: begin
        if (bit_tick) begin
          state_d       = StIdle;
          word_done     = ser_in;
          frame_error_d = ~ser_in;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign write = hold_valid_q & ~fifo.fifo_full;

  always_comb begin
    hold_valid_d = hold_valid_q;
    data_d       = data_q;
    overflow_d   = overflow_q;
    count_d      = count_q;
    if (write) begin
      hold_valid_d = 1'b0;
      count_d      = count_q + COUNT_WIDTH'(1);
    end
    // A write on this edge frees the register, so a new word may replace it.
    if (word_done) begin
      if (!hold_valid_q || write) begin
        hold_valid_d = 1'b1;
        data_d       = shift_q;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_write) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      hold_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      hold_valid_q  <= hold_valid_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
      count_q       <= count_d;
    end
  end

  assign fifo.fifo_data       = data_q;
  assign fifo.fifo_write_mode = write;
  assign fifo.fifo_enable     = ~reset;
  assign frame_error          = frame_error_q;
  assign overflow             = overflow_q;
  assign word_count           = count_q;

endmodule

// File: tb/tb_serial_fifo_writer.sv
// Scoreboard bench for serial_fifo_writer: words queued on send, popped on FIFO write.
module tb_serial_fifo_writer;

  localparam int unsigned DATA_SIZE   = 4;
  localparam int unsigned BIT_CYCLES  = 4;
  localparam int unsigned COUNT_WIDTH = 8;

  logic                   clk_write = 1'b0;
  logic                   reset     = 1'b1;
  logic                   ser_in    = 1'b1;
  logic                   frame_error;
  logic                   overflow;
  logic [COUNT_WIDTH-1:0] word_count;

  serial_fifo_writer_if #(.DATA_SIZE(DATA_SIZE)) fifo_if ();

  serial_fifo_writer #(
    .DATA_SIZE  (DATA_SIZE),
    .BIT_CYCLES (BIT_CYCLES),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk_write  (clk_write),
    .reset      (reset),
    .ser_in     (ser_in),
    .fifo       (fifo_if),
    .frame_error(frame_error),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk_write = ~clk_write;

  int unsigned          n_cmp = 0;
  int unsigned          n_err = 0;
  int                   cyc = 0;
  int                   frame_start = 0;
  int                   write_cyc = -1;
  int                   fe_cyc = -1;
  int                   wr_num = 0;
  int                   fe_num = 0;
  logic [DATA_SIZE-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk_write) cyc++;

  // A write request seen mid-cycle is committed by the FIFO on the next edge.
  always @(negedge clk_write) begin
    if (!reset) begin
      if (fifo_if.fifo_write_mode) begin
        wr_num++;
        write_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_write", 32'(fifo_if.fifo_data), 32'hdead);
        else                   check("write_data", 32'(fifo_if.fifo_data), 32'(exp_q.pop_front()));
      end
      if (frame_error) begin
        fe_num++;
        fe_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_write);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_SIZE-1:0] d, input logic stop);
    frame_start = cyc;
    ser_in = 1'b0;
    idle(BIT_CYCLES);
    for (int k = 0; k < DATA_SIZE; k++) begin
      ser_in = d[k];
      idle(BIT_CYCLES);
    end
    ser_in = stop;
    idle(BIT_CYCLES);
    ser_in = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle(2);
    check("rst_enable", 32'(fifo_if.fifo_enable), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    idle(1);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_data", 32'(fifo_if.fifo_data), 32'd0);
    check("rst_write_mode", 32'(fifo_if.fifo_write_mode), 32'd0);
    check("enable_after_rst", 32'(fifo_if.fifo_enable), 32'd1);
  endtask

  initial begin
    int wr0, fe0;
    fifo_if.fifo_full = 1'b0;
    #1;
    apply_reset();

    // Basic frame 0xA: write request visible after E22 for one cycle.
    wr0 = wr_num;
    exp_q.push_back(4'hA);
    send_frame(4'hA, 1'b1);
    idle(4);
    check("t1_latency", 32'(write_cyc - frame_start), 32'd23);
    check("t1_writes", 32'(wr_num - wr0), 32'd1);
    check("t1_count", 32'(word_count), 32'd1);
    check("t1_frame_error", 32'(fe_num), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // One-cycle glitch must be rejected silently.
    wr0 = wr_num;
    ser_in = 1'b0;
    idle(1);
    ser_in = 1'b1;
    idle(30);
    check("t2_writes", 32'(wr_num - wr0), 32'd0);
    check("t2_frame_error", 32'(fe_num), 32'd0);
    check("t2_count", 32'(word_count), 32'd1);

    // Bad stop bit: one-cycle frame_error at E22, nothing written.
    wr0 = wr_num;
    fe0 = fe_num;
    send_frame(4'hA, 1'b0);
    idle(4);
    check("t3_fe_pulses", 32'(fe_num - fe0), 32'd1);
    check("t3_fe_time", 32'(fe_cyc - frame_start), 32'd23);
    check("t3_writes", 32'(wr_num - wr0), 32'd0);
    check("t3_count", 32'(word_count), 32'd1);

    // Backpressure: second word dropped, first held until release.
    wr0 = wr_num;
    fifo_if.fifo_full = 1'b1;
    exp_q.push_back(4'h3);
    send_frame(4'h3, 1'b1);
    check("t4_no_overflow_yet", 32'(overflow), 32'd0);
    send_frame(4'hC, 1'b1);
    idle(1);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_hold_data", 32'(fifo_if.fifo_data), 32'h3);
    check("t4_write_mode", 32'(fifo_if.fifo_write_mode), 32'd0);
    idle(20);
    check("t4_still_held", 32'(fifo_if.fifo_data), 32'h3);
    check("t4_no_writes", 32'(wr_num - wr0), 32'd0);
    fifo_if.fifo_full = 1'b0;
    idle(5);
    check("t4_writes", 32'(wr_num - wr0), 32'd1);
    check("t4_count", 32'(word_count), 32'd2);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of frame 0x5, then a clean 0x9.
    apply_reset();
    fe0 = fe_num;
    ser_in = 1'b0;
    idle(BIT_CYCLES);
    ser_in = 1'b1;
    idle(BIT_CYCLES);
    ser_in = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    ser_in = 1'b1;
    idle(30);
    wr0 = wr_num;
    exp_q.push_back(4'h9);
    send_frame(4'h9, 1'b1);
    idle(4);
    check("t5_writes", 32'(wr_num - wr0), 32'd1);
    check("t5_count", 32'(word_count), 32'd1);
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_frame_error", 32'(fe_num - fe0), 32'd0);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // 256 back-to-back frames wrap the word counter to zero.
    apply_reset();
    wr0 = wr_num;
    for (int i = 0; i < 256; i++) begin
      logic [DATA_SIZE-1:0] d;
      d = DATA_SIZE'($urandom_range(0, (1 << DATA_SIZE) - 1));
      exp_q.push_back(d);
      send_frame(d, 1'b1);
    end
    idle(4);
    check("t6_writes", 32'(wr_num - wr0), 32'd256);
    check("t6_count_wrap", 32'(word_count), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
